pio_gen: RTL and testbench

- Parametrised general-purpose I/O block with an Avalon-MM slave; successor to the fixed 8-bit LED PIO in the Qsys system.
- Adds:
  - configurable width
  - per-bit direction
  - atomic set/clear of outputs
  - synchronised inputs
  - per-bit rising/falling edge capture
  - maskable level interrupt
- Pins leave as split in/out/oe vectors. The system top builds the inout conduit from them.

---
 rtl/pio_gen_pkg.sv | 29 ++
 rtl/pio_gen_if.sv | 20 ++
 rtl/pio_sync_edge.sv | 42 ++++
 rtl/pio_gen.sv | 106 ++++++++++
 tb/tb_pio_gen.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pio_gen_pkg.sv
// rtl/pio_gen_pkg.sv - shared constants, register-file struct and helpers for pio_gen
package pio_gen_pkg;

    localparam int AVS_DATA_W = 32;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd6;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd7;

    typedef struct packed {
        logic [AVS_DATA_W-1:0] dir;
        logic [AVS_DATA_W-1:0] out;
        logic [AVS_DATA_W-1:0] mask;
        logic [AVS_DATA_W-1:0] cap;
        logic [AVS_DATA_W-1:0] rise;
        logic [AVS_DATA_W-1:0] fall;
    } pio_reg_t;

    // Low w bits set; used to keep unimplemented register bits at zero.
    function automatic logic [AVS_DATA_W-1:0] width_mask(input int w);
        return {AVS_DATA_W{1'b1}} >> (AVS_DATA_W - w);
    endfunction

endpackage

// File: rtl/pio_gen_if.sv
// rtl/pio_gen_if.sv - Avalon-MM register bus bundle for pio_gen
interface pio_gen_if;
    import pio_gen_pkg::*;

    logic [2:0]            avs_address;
    logic                  avs_read;
    logic                  avs_write;
    logic [AVS_DATA_W-1:0] avs_writedata;
    logic [AVS_DATA_W-1:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/pio_sync_edge.sv
// rtl/pio_sync_edge.sv - pin synchroniser, edge history and raw rise/fall pulses
module pio_sync_edge #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pin_in,
    output logic [DATA_W-1:0] sync,
    output logic [DATA_W-1:0] rise_pulse,
    output logic [DATA_W-1:0] fall_pulse
);

    logic [SYNC_STAGES-1:0][DATA_W-1:0] stage_q, stage_d;
    logic [DATA_W-1:0]                  prev_q, prev_d;
    logic                               armed_q, armed_d;

    always_comb begin
        stage_d = {stage_q[SYNC_STAGES-2:0], pin_in};
        prev_d  = stage_q[SYNC_STAGES-1];
        armed_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
            prev_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            stage_q <= stage_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

    assign sync = stage_q[SYNC_STAGES-1];

    // History is meaningless until it has been loaded once after reset.
    assign rise_pulse =  sync & ~prev_q & {DATA_W{armed_q}};
    assign fall_pulse = ~sync &  prev_q & {DATA_W{armed_q}};

endmodule

// File: rtl/pio_gen.sv
// rtl/pio_gen.sv - parametrised GPIO with direction, set/clear, edge capture and irq
module pio_gen
    import pio_gen_pkg::*;
#(
    parameter int              DATA_W      = 8,
    parameter int              SYNC_STAGES = 2,
    parameter logic [31:0]     DIR_RESET   = 32'h0,
    parameter logic [31:0]     OUT_RESET   = 32'h0,
    parameter logic [31:0]     RISE_RESET  = 32'h0,
    parameter logic [31:0]     FALL_RESET  = 32'h0
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    pio_gen_if.slave          avs,
    output logic              irq,
    input  logic [DATA_W-1:0] pio_in,
    output logic [DATA_W-1:0] pio_out,
    output logic [DATA_W-1:0] pio_oe
);

    localparam logic [AVS_DATA_W-1:0] W_MASK = width_mask(DATA_W);

    localparam pio_reg_t REG_RESET = '{
        dir:  DIR_RESET & W_MASK,
        out:  OUT_RESET & W_MASK,
        mask: '0,
        cap:  '0,
        rise: RISE_RESET & W_MASK,
        fall: FALL_RESET & W_MASK
    };

    pio_reg_t              reg_q, reg_d;
    logic [AVS_DATA_W-1:0] rdata_q, rdata_d;

    logic [DATA_W-1:0]     sync, rise_pulse, fall_pulse;
    logic [AVS_DATA_W-1:0] sync_ext, edge_set, wd;

    pio_sync_edge #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk        (clk_clk),
        .rst_n      (reset_reset_n),
        .pin_in     (pio_in),
        .sync       (sync),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    always_comb begin
        sync_ext                 = '0;
        sync_ext[DATA_W-1:0]     = sync;
        edge_set                 = '0;
        edge_set[DATA_W-1:0]     = (rise_pulse & reg_q.rise[DATA_W-1:0])
                                 | (fall_pulse & reg_q.fall[DATA_W-1:0]);
        wd                       = avs.avs_writedata & W_MASK;
        reg_d                    = reg_q;
        rdata_d                  = rdata_q;

        // Reads decode from the current flops, so a same-cycle write is not seen.
        if (avs.avs_read) begin
            case (avs.avs_address)
                ADDR_DATA:     rdata_d = sync_ext;
                ADDR_DIR:      rdata_d = reg_q.dir;
                ADDR_IRQ_MASK: rdata_d = reg_q.mask;
                ADDR_EDGE_CAP: rdata_d = reg_q.cap;
                ADDR_OUTSET:   rdata_d = '0;
                ADDR_OUTCLR:   rdata_d = '0;
                ADDR_RISE_EN:  rdata_d = reg_q.rise;
                ADDR_FALL_EN:  rdata_d = reg_q.fall;
            endcase
        end

        if (avs.avs_write) begin
            case (avs.avs_address)
                ADDR_DATA:     reg_d.out  = wd;
                ADDR_DIR:      reg_d.dir  = wd;
                ADDR_IRQ_MASK: reg_d.mask = wd;
                ADDR_EDGE_CAP: reg_d.cap  = reg_q.cap & ~wd;
                ADDR_OUTSET:   reg_d.out  = reg_q.out | wd;
                ADDR_OUTCLR:   reg_d.out  = reg_q.out & ~wd;
                ADDR_RISE_EN:  reg_d.rise = wd;
                ADDR_FALL_EN:  reg_d.fall = wd;
            endcase
        end

        // A new edge overrides a clear of the same bit.
        reg_d.cap = reg_d.cap | edge_set;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            reg_q   <= REG_RESET;
            rdata_q <= '0;
        end else begin
            reg_q   <= reg_d;
            rdata_q <= rdata_d;
        end
    end

    assign avs.avs_readdata = rdata_q;
    assign pio_out          = reg_q.out[DATA_W-1:0];
    assign pio_oe           = reg_q.dir[DATA_W-1:0];
    assign irq              = |(reg_q.cap & reg_q.mask);

endmodule

// File: tb/tb_pio_gen.sv
// tb/tb_pio_gen.sv - randomized self-checking bench for pio_gen against a register-level model
module tb_pio_gen;
    import pio_gen_pkg::*;

    localparam int          DW     = 8;
    localparam int          SS     = 2;
    localparam logic [31:0] DIR_R  = 32'h0F;
    localparam logic [31:0] OUT_R  = 32'hA5;
    localparam logic [31:0] RISE_R = 32'hF0;
    localparam logic [31:0] FALL_R = 32'h0F;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] pio_in = '0;
    logic [DW-1:0] pio_out, pio_oe;
    logic          irq;

    pio_gen_if bus ();

    pio_gen #(
        .DATA_W      (DW),
        .SYNC_STAGES (SS),
        .DIR_RESET   (DIR_R),
        .OUT_RESET   (OUT_R),
        .RISE_RESET  (RISE_R),
        .FALL_RESET  (FALL_R)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .avs           (bus),
        .irq           (irq),
        .pio_in        (pio_in),
        .pio_out       (pio_out),
        .pio_oe        (pio_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: registers as plain values, pins as a history of samples.
    logic [DW-1:0] m_dir, m_out, m_mask, m_cap, m_rise, m_fall;
    logic [31:0]   m_rd;
    logic [DW-1:0] hist[$];
    bit            m_valid = 1'b0;

    function automatic logic [DW-1:0] hist_at(input int d);
        if (d < hist.size()) return hist[d];
        return '0;
    endfunction

    task automatic model_step();
        logic [DW-1:0] s, p, setb, wd;
        if (!rst_n) begin
            m_dir  = DIR_R[DW-1:0];
            m_out  = OUT_R[DW-1:0];
            m_rise = RISE_R[DW-1:0];
            m_fall = FALL_R[DW-1:0];
            m_mask = '0;
            m_cap  = '0;
            m_rd   = '0;
            hist.delete();
            m_valid = 1'b1;
            return;
        end
        hist.push_front(pio_in);
        if (hist.size() > SS + 2) void'(hist.pop_back());
        // Value seen as synchronised just before this edge, and the one before that.
        s = hist_at(SS);
        p = hist_at(SS + 1);
        setb = (hist.size() >= 2) ? ((s & ~p & m_rise) | (~s & p & m_fall)) : '0;
        if (bus.avs_read) begin
            case (bus.avs_address)
                3'd0: m_rd = 32'(s);
                3'd1: m_rd = 32'(m_dir);
                3'd2: m_rd = 32'(m_mask);
                3'd3: m_rd = 32'(m_cap);
                3'd6: m_rd = 32'(m_rise);
                3'd7: m_rd = 32'(m_fall);
                default: m_rd = 32'h0;
            endcase
        end
        wd = bus.avs_writedata[DW-1:0];
        if (bus.avs_write) begin
            case (bus.avs_address)
                3'd0: m_out  = wd;
                3'd1: m_dir  = wd;
                3'd2: m_mask = wd;
                3'd3: m_cap  = m_cap & ~wd;
                3'd4: m_out  = m_out | wd;
                3'd5: m_out  = m_out & ~wd;
                3'd6: m_rise = wd;
                default: m_fall = wd;
            endcase
        end
        m_cap = m_cap | setb;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check_eq("readdata", bus.avs_readdata, m_rd);
            check_eq("pio_out", 32'(pio_out), 32'(m_out));
            check_eq("pio_oe", 32'(pio_oe), 32'(m_dir));
            check_eq("irq", 32'(irq), 32'(|(m_cap & m_mask)));
        end
    end

    task automatic bus_idle();
        @(negedge clk);
        bus.avs_read  = 1'b0;
        bus.avs_write = 1'b0;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        bus.avs_read      = 1'b0;
        @(negedge clk);
        bus.avs_write     = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        bus.avs_write   = 1'b0;
        @(negedge clk);
        bus.avs_read    = 1'b0;
        d = bus.avs_readdata;
    endtask

    logic [31:0] rd;
    logic [31:0] exp_rst [8];

    initial begin
        bus.avs_address   = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Reset values through pins and every register address
        check_eq("rst_oe", 32'(pio_oe), 32'h0F);
        check_eq("rst_out", 32'(pio_out), 32'hA5);
        check_eq("rst_irq", 32'(irq), 32'h0);
        exp_rst = '{32'h0, 32'h0F, 32'h0, 32'h0, 32'h0, 32'h0, 32'hF0, 32'h0F};
        for (int a = 0; a < 8; a++) begin
            bus_rd(3'(a), rd);
            check_eq($sformatf("rst_rd%0d", a), rd, exp_rst[a]);
        end

        // Output register write, set and clear
        bus_wr(3'd0, 32'hFFFF_FF3C);
        check_eq("out_wr", 32'(pio_out), 32'h3C);
        bus_wr(3'd4, 32'h81);
        check_eq("out_set", 32'(pio_out), 32'hBD);
        bus_wr(3'd5, 32'h0C);
        check_eq("out_clr", 32'(pio_out), 32'hB1);
        bus_rd(3'd4, rd);
        check_eq("rd_outset", rd, 32'h0);
        bus_rd(3'd5, rd);
        check_eq("rd_outclr", rd, 32'h0);

        // Rising edge on bit 0 captured but unmasked; falling on bit 1 raises irq
        pio_in = 8'h02;
        repeat (4) bus_idle();
        bus_wr(3'd6, 32'h01);
        bus_wr(3'd7, 32'h02);
        bus_wr(3'd2, 32'h02);
        bus_wr(3'd3, 32'hFF);
        @(negedge clk);
        pio_in[0] = 1'b1;
        repeat (3) bus_idle();
        bus_rd(3'd3, rd);
        check_eq("cap_rise", rd, 32'h01);
        check_eq("irq_unmasked", 32'(irq), 32'h0);
        @(negedge clk);
        pio_in[1] = 1'b0;
        bus_idle();
        bus_idle();
        check_eq("irq_early", 32'(irq), 32'h0);
        bus_idle();
        check_eq("irq_n2", 32'(irq), 32'h1);
        bus_rd(3'd3, rd);
        check_eq("cap_fall", rd, 32'h03);

        // Clear collides with a fresh falling edge on the same bit
        pio_in[1] = 1'b1;
        repeat (4) bus_idle();
        @(negedge clk);
        pio_in[1] = 1'b0;
        bus_idle();
        @(negedge clk);
        bus.avs_address   = 3'd3;
        bus.avs_writedata = 32'h02;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write = 1'b0;
        check_eq("irq_setwins", 32'(irq), 32'h1);
        bus_rd(3'd3, rd);
        check_eq("cap_setwins", rd, 32'h03);
        bus_wr(3'd3, 32'h03);
        check_eq("irq_cleared", 32'(irq), 32'h0);
        bus_rd(3'd3, rd);
        check_eq("cap_cleared", rd, 32'h0);

        // Back-to-back reads, one cycle latency, upper bits zero
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            if (a > 0) check_eq("rd_upper", bus.avs_readdata & 32'hFFFF_FF00, 32'h0);
            bus.avs_address = 3'(a);
            bus.avs_read    = 1'b1;
            bus.avs_write   = 1'b0;
        end
        @(negedge clk);
        check_eq("rd_upper", bus.avs_readdata & 32'hFFFF_FF00, 32'h0);
        bus.avs_read = 1'b0;

        // Random traffic on pins and bus, with an asynchronous reset pulse mid-burst
        bus_wr(3'd6, 32'hFF);
        bus_wr(3'd7, 32'hFF);
        bus_wr(3'd2, 32'hFF);
        for (int i = 0; i < 400; i++) begin
            int op;
            @(negedge clk);
            op = int'($urandom_range(0, 3));
            pio_in            = DW'($urandom);
            bus.avs_address   = 3'($urandom);
            bus.avs_writedata = $urandom;
            bus.avs_read      = (op == 1) || (op == 3);
            bus.avs_write     = (op == 2) || (op == 3);
            if (i == 200) begin
                #3 rst_n = 1'b0;
                #1;
                check_eq("arst_out", 32'(pio_out), 32'hA5);
                check_eq("arst_oe", 32'(pio_oe), 32'h0F);
                check_eq("arst_irq", 32'(irq), 32'h0);
                check_eq("arst_rd", bus.avs_readdata, 32'h0);
            end
            if (i == 204) #2 rst_n = 1'b1;
        end
        bus_idle();
        bus_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
